// File: rtl/tdc_avg_sampler.sv
// Delay-line TDC: two-rank tap sampling, popcount encode and 2^k sample averaging.
// Result is held on a valid/ack handshake together with a sticky range-error flag.

module DLY2_X0P5N_A9PP84TR_C14 (
    input  logic A,
    output logic Z
);
    assign Z = A;
endmodule

module tdc_avg_sampler #(
    parameter int N_STAGES     = 64,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int CODE_W       = $clog2(N_STAGES + 1),
    parameter int ACC_W        = CODE_W + MAX_AVG_LOG2,
    parameter int SEL_W        = $clog2(MAX_AVG_LOG2 + 1)
) (
    input  logic                i_Clk_Ref,
    input  logic                i_RST_p,
    input  logic                i_CLK_Target,
    input  logic                i_Start,
    input  logic [SEL_W-1:0]    i_Avg_Sel,
    input  logic                i_Ack,
    output logic                o_Busy,
    output logic                o_Valid,
    output logic [CODE_W-1:0]   o_Code,
    output logic                o_Range_Err,
    output logic [N_STAGES-1:0] o_Therm
);

    localparam int CNT_W = MAX_AVG_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        ACC,
        DONE
    } state_t;

    logic [N_STAGES-1:0] taps;
    logic [N_STAGES-1:0] rank1;
    logic [N_STAGES-1:0] rank2;
    logic [CODE_W-1:0]   pop;
    logic [CODE_W-1:0]   code_q;
    logic                rerr_q;

    state_t              state;
    state_t              nxt;
    logic [SEL_W-1:0]    k_q;
    logic [SEL_W-1:0]    k_clamp;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic                sticky;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_lim;
    logic                last;
    logic [1:0]          fcnt;

    // Per-stage local nets keep the chain out of a single self-referencing vector
    for (genvar j = 0; j < N_STAGES; j++) begin : g_dly
        logic a;
        logic z;
        if (j == 0) begin : g_first
            assign a = i_CLK_Target;
        end else begin : g_next
            assign a = g_dly[j-1].z;
        end
        DLY2_X0P5N_A9PP84TR_C14 u_cell (
            .A (a),
            .Z (z)
        );
        assign taps[j] = z;
    end

    always_ff @(posedge i_Clk_Ref or posedge i_RST_p) begin
        if (i_RST_p) begin
            rank1 <= '0;
            rank2 <= '0;
        end else begin
            rank1 <= taps;
            rank2 <= rank1;
        end
    end

    // Population count tolerates bubbles in the thermometer sample
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            pop = pop + CODE_W'(rank2[i]);
        end
    end

    always_ff @(posedge i_Clk_Ref or posedge i_RST_p) begin
        if (i_RST_p) begin
            code_q <= '0;
            rerr_q <= 1'b0;
        end else begin
            code_q <= pop;
            rerr_q <= (~|rank2) | (&rank2);
        end
    end

    assign k_clamp = (i_Avg_Sel > SEL_W'(MAX_AVG_LOG2)) ?
                     SEL_W'(MAX_AVG_LOG2) : i_Avg_Sel;
    assign cnt_lim = CNT_W'((1 << k_q) - 1);
    assign last    = (cnt == cnt_lim);
    assign sum     = acc + ACC_W'(code_q);

    always_ff @(posedge i_Clk_Ref or posedge i_RST_p) begin
        if (i_RST_p) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (i_Start) nxt = FLUSH;
            FLUSH:   if (fcnt == 2'd2) nxt = ACC;
            ACC:     if (last) nxt = DONE;
            DONE:    if (i_Ack) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk_Ref or posedge i_RST_p) begin
        if (i_RST_p) begin
            k_q         <= '0;
            acc         <= '0;
            sticky      <= 1'b0;
            cnt         <= '0;
            fcnt        <= '0;
            o_Code      <= '0;
            o_Range_Err <= 1'b0;
            o_Valid     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_Start) begin
                        k_q    <= k_clamp;
                        acc    <= '0;
                        sticky <= 1'b0;
                        cnt    <= '0;
                        fcnt   <= '0;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 2'd1;
                end
                ACC: begin
                    acc    <= sum;
                    sticky <= sticky | rerr_q;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        o_Code      <= CODE_W'(sum >> k_q);
                        o_Range_Err <= sticky | rerr_q;
                        o_Valid     <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_Ack) o_Valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_Busy  = (state != IDLE);
    assign o_Therm = rank2;

endmodule

// File: tb/tb_tdc_avg_sampler.sv
// Directed bench for tdc_avg_sampler; taps are forced to model delay-line patterns.

module tb_tdc_avg_sampler;

    localparam logic [63:0] P20  = 64'h0000_0000_000F_FFFF;
    localparam logic [63:0] P21  = 64'h0000_0000_001F_FFFF;
    localparam logic [63:0] PBUB = 64'h0000_0000_001B_FFFF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tgt = 1'b0;
    logic        start = 1'b1;
    logic        ack = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        busy;
    logic        valid;
    logic [6:0]  code;
    logic        rerr;
    logic [63:0] therm;

    int n_cmp = 0;
    int n_bad = 0;

    logic alt_en = 1'b0;
    logic alt = 1'b0;

    tdc_avg_sampler dut (
        .i_Clk_Ref    (clk),
        .i_RST_p      (rst),
        .i_CLK_Target (tgt),
        .i_Start      (start),
        .i_Avg_Sel    (sel),
        .i_Ack        (ack),
        .o_Busy       (busy),
        .o_Valid      (valid),
        .o_Code       (code),
        .o_Range_Err  (rerr),
        .o_Therm      (therm)
    );

    always #5 clk = ~clk;

    // Target phase alternates between 20 and 21 set taps
    always @(negedge clk) begin
        if (alt_en) begin
            alt = ~alt;
            if (alt) force dut.taps = P21;
            else force dut.taps = P20;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [2:0] s);
        sel = s;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int lat, input string tag);
        step(lat - 1);
        chk({tag, "_early"}, 64'(valid), 64'd0);
        step(1);
        chk({tag, "_valid"}, 64'(valid), 64'd1);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk({tag, "_ack_valid"}, 64'(valid), 64'd0);
        chk({tag, "_ack_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_code"}, 64'(code), 64'd0);
        chk({tag, "_rerr"}, 64'(rerr), 64'd0);
        chk({tag, "_therm"}, therm, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            tgt = 1'($urandom);
            step(1);
        end
        chk_zero("rst");
        rst = 1'b0;
        start = 1'b0;
        step(3);
        chk("rst_rel_busy", 64'(busy), 64'd0);
        chk("rst_rel_valid", 64'(valid), 64'd0);

        tgt = 1'b1;
        step(3);
        chk("therm_ones", therm, ONES);
        do_start(3'd2);
        chk("hi_busy", 64'(busy), 64'd1);
        wait_valid(7, "hi");
        chk("hi_code", 64'(code), 64'd64);
        chk("hi_rerr", 64'(rerr), 64'd1);
        do_ack("hi");

        tgt = 1'b0;
        step(3);
        do_start(3'd2);
        wait_valid(7, "lo");
        chk("lo_code", 64'(code), 64'd0);
        chk("lo_rerr", 64'(rerr), 64'd1);
        do_ack("lo");

        force dut.taps = P20;
        alt_en = 1'b1;
        step(3);
        do_start(3'd1);
        wait_valid(5, "avg1");
        chk("avg1_code", 64'(code), 64'd20);
        chk("avg1_rerr", 64'(rerr), 64'd0);
        do_ack("avg1");
        alt_en = 1'b0;

        force dut.taps = P20;
        step(3);
        sel = 3'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        force dut.taps = P21;
        step(1);
        force dut.taps = P20;
        step(2);
        chk("k0_early", 64'(valid), 64'd0);
        step(1);
        chk("k0_valid", 64'(valid), 64'd1);
        chk("k0_code", 64'(code), 64'd21);
        do_ack("k0");

        force dut.taps = PBUB;
        step(3);
        chk("bub_therm", therm, PBUB);
        do_start(3'd2);
        wait_valid(7, "bub");
        chk("bub_code", 64'(code), 64'd20);
        chk("bub_rerr", 64'(rerr), 64'd0);

        force dut.taps = P21;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_code", 64'(code), 64'd20);
        end

        ack = 1'b1;
        start = 1'b1;
        step(1);
        ack = 1'b0;
        start = 1'b0;
        chk("ackst_busy", 64'(busy), 64'd0);
        chk("ackst_valid", 64'(valid), 64'd0);
        step(6);
        chk("ackst_busy2", 64'(busy), 64'd0);
        chk("ackst_valid2", 64'(valid), 64'd0);

        do_start(3'd1);
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(1);
        chk("ign_early", 64'(valid), 64'd0);
        step(1);
        chk("ign_valid", 64'(valid), 64'd1);
        chk("ign_code", 64'(code), 64'd21);
        do_ack("ign");
        step(8);
        chk("ign_busy", 64'(busy), 64'd0);
        chk("ign_valid2", 64'(valid), 64'd0);

        do_start(3'd7);
        wait_valid(19, "clamp");
        chk("clamp_code", 64'(code), 64'd21);
        do_ack("clamp");

        do_start(3'd4);
        step(9);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        step(2);
        rst = 1'b0;
        step(25);
        chk("mid_after_valid", 64'(valid), 64'd0);
        chk("mid_after_busy", 64'(busy), 64'd0);

        do_start(3'd4);
        wait_valid(19, "post");
        chk("post_code", 64'(code), 64'd21);
        chk("post_rerr", 64'(rerr), 64'd0);
        do_ack("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
